// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: axis phase encoding,
// default 640x480-style timing constants and width-derivation helpers.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    DISPLAY     = 2'd2,
    FRONT_PORCH = 2'd3
  } axis_state_e;

  localparam int   DEF_H_SYNC   = 192;
  localparam int   DEF_H_BP     = 96;
  localparam int   DEF_H_DISP   = 1280;
  localparam int   DEF_H_FP     = 32;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BP     = 29;
  localparam int   DEF_V_DISP   = 480;
  localparam int   DEF_V_FP     = 10;
  localparam int   DEF_H_SCALE  = 10;
  localparam int   DEF_V_SCALE  = 5;
  localparam logic DEF_SYNC_POL = 1'b0;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Phase counter width: enough for the longest phase on the axis.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return width_of(max4(a, b, c, d));
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: SYNC/BACK_PORCH/DISPLAY/FRONT_PORCH phase machine with a
// pixel-replication sub-counter and the logical coordinate it produces.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int CW = 11,
  parameter int SW = 4,
  parameter int PW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW:0]   len_sync,
  input  logic [CW:0]   len_bp,
  input  logic [CW:0]   len_disp,
  input  logic [CW:0]   len_fp,
  input  logic [SW-1:0] scale,
  output axis_state_e   state_nxt,
  output logic [PW-1:0] coord,
  output logic          last_nxt
);

  axis_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [PW-1:0] coord_q, coord_d;
  logic [CW:0]   len_cur_s;
  logic          phase_done_s;

  always_comb begin
    len_cur_s = len_fp;
    case (state_q)
      SYNC:        len_cur_s = len_sync;
      BACK_PORCH:  len_cur_s = len_bp;
      DISPLAY:     len_cur_s = len_disp;
      FRONT_PORCH: len_cur_s = len_fp;
      default:     len_cur_s = len_fp;
    endcase
  end

  assign phase_done_s = ({1'b0, cnt_q} == (len_cur_s - (CW+1)'(1)));

  // Every phase change clears counter, sub-counter and coordinate, which is
  // what keeps the coordinate at 0 outside DISPLAY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    coord_d = coord_q;
    if (advance) begin
      if (phase_done_s) begin
        cnt_d   = '0;
        sub_d   = '0;
        coord_d = '0;
        case (state_q)
          SYNC:        state_d = BACK_PORCH;
          BACK_PORCH:  state_d = DISPLAY;
          DISPLAY:     state_d = FRONT_PORCH;
          FRONT_PORCH: state_d = SYNC;
          default:     state_d = SYNC;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == DISPLAY) begin
          if (sub_q == (scale - SW'(1))) begin
            sub_d   = '0;
            coord_d = coord_q + PW'(1);
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      sub_q   <= '0;
      coord_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      coord_q <= coord_d;
    end
  end

  assign state_nxt = state_d;
  assign coord     = coord_q;
  assign last_nxt  = (state_d == FRONT_PORCH) && ({1'b0, cnt_d} == (len_fp - (CW+1)'(1)));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis timers plus
// registered sync, display-enable and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   H_DISP   = DEF_H_DISP,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   V_DISP   = DEF_V_DISP,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   H_SCALE  = DEF_H_SCALE,
  parameter int   V_SCALE  = DEF_V_SCALE,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   CE,
  output logic [width_of(H_DISP/H_SCALE)-1:0]    HPIXEL,
  output logic [width_of(V_DISP/V_SCALE)-1:0]    VPIXEL,
  output logic                                   DISP_EN,
  output logic                                   VGA_HSYNC,
  output logic                                   VGA_VSYNC,
  output logic                                   LINE_END,
  output logic                                   FRAME_END
);

  localparam int H_CW = cnt_width(H_SYNC, H_BP, H_DISP, H_FP);
  localparam int V_CW = cnt_width(V_SYNC, V_BP, V_DISP, V_FP);
  localparam int H_SW = width_of(H_SCALE + 1);
  localparam int V_SW = width_of(V_SCALE + 1);
  localparam int H_PW = width_of(H_DISP / H_SCALE);
  localparam int V_PW = width_of(V_DISP / V_SCALE);

  if ((H_SYNC < 1) || (H_BP < 1) || (H_DISP < 1) || (H_FP < 1) ||
      (V_SYNC < 1) || (V_BP < 1) || (V_DISP < 1) || (V_FP < 1) ||
      (H_SCALE < 1) || (V_SCALE < 1) ||
      ((H_DISP % ((H_SCALE < 1) ? 1 : H_SCALE)) != 0) ||
      ((V_DISP % ((V_SCALE < 1) ? 1 : V_SCALE)) != 0)) begin : g_bad_params
    $fatal(1, "vga_timing_gen: zero-length phase or display not a multiple of scale");
  end

  axis_state_e h_state_nxt_s, v_state_nxt_s;
  logic        h_last_nxt_s, v_last_nxt_s;
  logic        v_adv_s;
  logic        disp_en_d, disp_en_q;
  logic        hsync_d, hsync_q;
  logic        vsync_d, vsync_q;
  logic        line_end_d, line_end_q;
  logic        frame_end_d, frame_end_q;

  // line_end_q is exactly the horizontal last-cycle flag of the current state.
  assign v_adv_s = CE & line_end_q;

  vga_axis_timer #(.CW(H_CW), .SW(H_SW), .PW(H_PW)) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .advance   (CE),
    .len_sync  ((H_CW+1)'(H_SYNC)),
    .len_bp    ((H_CW+1)'(H_BP)),
    .len_disp  ((H_CW+1)'(H_DISP)),
    .len_fp    ((H_CW+1)'(H_FP)),
    .scale     (H_SW'(H_SCALE)),
    .state_nxt (h_state_nxt_s),
    .coord     (HPIXEL),
    .last_nxt  (h_last_nxt_s)
  );

  vga_axis_timer #(.CW(V_CW), .SW(V_SW), .PW(V_PW)) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .advance   (v_adv_s),
    .len_sync  ((V_CW+1)'(V_SYNC)),
    .len_bp    ((V_CW+1)'(V_BP)),
    .len_disp  ((V_CW+1)'(V_DISP)),
    .len_fp    ((V_CW+1)'(V_FP)),
    .scale     (V_SW'(V_SCALE)),
    .state_nxt (v_state_nxt_s),
    .coord     (VPIXEL),
    .last_nxt  (v_last_nxt_s)
  );

  // Decode from next state so the registered outputs line up with the axes.
  always_comb begin
    disp_en_d   = (h_state_nxt_s == DISPLAY) && (v_state_nxt_s == DISPLAY);
    hsync_d     = (h_state_nxt_s == SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = (v_state_nxt_s == SYNC) ? SYNC_POL : ~SYNC_POL;
    line_end_d  = h_last_nxt_s;
    frame_end_d = h_last_nxt_s & v_last_nxt_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_en_q   <= 1'b0;
      hsync_q     <= SYNC_POL;
      vsync_q     <= SYNC_POL;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (CE) begin
      disp_en_q   <= disp_en_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign DISP_EN   = disp_en_q;
  assign VGA_HSYNC = hsync_q;
  assign VGA_VSYNC = vsync_q;
  assign LINE_END  = line_end_q;
  assign FRAME_END = frame_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-timing and a small active-high instance share
// clock, reset and CE; expected outputs come from raster position arithmetic.
module tb_vga_timing_gen;

  typedef struct packed {
    int hs; int hb; int hd; int hf;
    int vs; int vb; int vd; int vf;
    int hsc; int vsc;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic [31:0] hpix;
    logic [31:0] vpix;
    logic disp; logic hsync; logic vsync; logic le; logic fe;
  } exp_t;

  localparam cfg_t CFG_D = '{hs:192, hb:96, hd:1280, hf:32, vs:2, vb:29, vd:480, vf:10,
                             hsc:10, vsc:5, pol:1'b0};
  localparam cfg_t CFG_S = '{hs:4, hb:2, hd:8, hf:2, vs:1, vb:1, vd:4, vf:1,
                             hsc:2, vsc:2, pol:1'b1};

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [6:0] d_hpix, d_vpix;
  logic       d_disp, d_hs, d_vs, d_le, d_fe;
  logic [1:0] s_hpix;
  logic [0:0] s_vpix;
  logic       s_disp, s_hs, s_vs, s_le, s_fe;

  int   n_assert = 0;
  int   n_fail = 0;
  int   hc_d, vl_d, hc_s, vl_s;
  int   cyc = 0;
  bit   meas = 1'b0;
  int   last_le = -1;
  int   last_fe = -1;
  int   hs_low = 0;
  exp_t q_d[$];
  exp_t q_s[$];

  always #5 clk = ~clk;

  vga_timing_gen u_dut_d (
    .clk(clk), .reset(reset), .CE(ce),
    .HPIXEL(d_hpix), .VPIXEL(d_vpix), .DISP_EN(d_disp),
    .VGA_HSYNC(d_hs), .VGA_VSYNC(d_vs), .LINE_END(d_le), .FRAME_END(d_fe)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(2), .H_DISP(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1),
    .H_SCALE(2), .V_SCALE(2), .SYNC_POL(1'b1)
  ) u_dut_s (
    .clk(clk), .reset(reset), .CE(ce),
    .HPIXEL(s_hpix), .VPIXEL(s_vpix), .DISP_EN(s_disp),
    .VGA_HSYNC(s_hs), .VGA_VSYNC(s_vs), .LINE_END(s_le), .FRAME_END(s_fe)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
    end
  endtask

  function automatic exp_t model(input cfg_t c, input int hc, input int vl);
    exp_t e;
    int   hd0, vd0, htot, vtot;
    bit   hin, vin;
    hd0    = c.hs + c.hb;
    vd0    = c.vs + c.vb;
    htot   = c.hs + c.hb + c.hd + c.hf;
    vtot   = c.vs + c.vb + c.vd + c.vf;
    hin    = (hc >= hd0) && (hc < hd0 + c.hd);
    vin    = (vl >= vd0) && (vl < vd0 + c.vd);
    e.hpix = hin ? 32'((hc - hd0) / c.hsc) : 32'd0;
    e.vpix = vin ? 32'((vl - vd0) / c.vsc) : 32'd0;
    e.disp = hin && vin;
    e.hsync = (hc < c.hs) ? c.pol : ~c.pol;
    e.vsync = (vl < c.vs) ? c.pol : ~c.pol;
    e.le   = (hc == htot - 1);
    e.fe   = e.le && (vl == vtot - 1);
    return e;
  endfunction

  task automatic adv(input cfg_t c, inout int hc, inout int vl);
    hc++;
    if (hc == c.hs + c.hb + c.hd + c.hf) begin
      hc = 0;
      vl++;
      if (vl == c.vs + c.vb + c.vd + c.vf) vl = 0;
    end
  endtask

  task automatic push_expected();
    q_d.push_back(model(CFG_D, hc_d, vl_d));
    q_s.push_back(model(CFG_S, hc_s, vl_s));
  endtask

  task automatic compare_outputs();
    exp_t e;
    e = q_d.pop_front();
    check_eq("d.HPIXEL",    32'(d_hpix), e.hpix);
    check_eq("d.VPIXEL",    32'(d_vpix), e.vpix);
    check_eq("d.DISP_EN",   32'(d_disp), 32'(e.disp));
    check_eq("d.VGA_HSYNC", 32'(d_hs),   32'(e.hsync));
    check_eq("d.VGA_VSYNC", 32'(d_vs),   32'(e.vsync));
    check_eq("d.LINE_END",  32'(d_le),   32'(e.le));
    check_eq("d.FRAME_END", 32'(d_fe),   32'(e.fe));
    e = q_s.pop_front();
    check_eq("s.HPIXEL",    32'(s_hpix), e.hpix);
    check_eq("s.VPIXEL",    32'(s_vpix), e.vpix);
    check_eq("s.DISP_EN",   32'(s_disp), 32'(e.disp));
    check_eq("s.VGA_HSYNC", 32'(s_hs),   32'(e.hsync));
    check_eq("s.VGA_VSYNC", 32'(s_vs),   32'(e.vsync));
    check_eq("s.LINE_END",  32'(s_le),   32'(e.le));
    check_eq("s.FRAME_END", 32'(s_fe),   32'(e.fe));
    if (meas) begin
      if (d_hs == 1'b0) hs_low++;
      if (d_le) begin
        if (last_le >= 0) begin
          check_eq("d.line_period", 32'(cyc - last_le), 32'd1600);
          check_eq("d.hsync_low",   32'(hs_low),        32'd192);
        end
        last_le = cyc;
        hs_low  = 0;
      end
      if (s_fe) begin
        if (last_fe >= 0) check_eq("s.frame_period", 32'(cyc - last_fe), 32'd112);
        last_fe = cyc;
      end
    end
  endtask

  // Called just after a falling edge; ends just after the next falling edge.
  task automatic run_cycle(input bit ce_v);
    ce = ce_v;
    if (ce_v) begin
      adv(CFG_D, hc_d, vl_d);
      adv(CFG_S, hc_s, vl_s);
    end
    push_expected();
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset: values must appear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    hc_d = 0; vl_d = 0; hc_s = 0; vl_s = 0;
    push_expected();
    compare_outputs();
    ce = 1'b1;
    @(posedge clk);
    #1;
    push_expected();
    compare_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    push_expected();
    compare_outputs();
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b0;
    hc_d = 0; vl_d = 0; hc_s = 0; vl_s = 0;
    @(negedge clk);
    do_reset();
    meas = 1'b1;
    repeat (37 * 1600 + 400) run_cycle(1'b1);
    meas = 1'b0;
    for (int i = 0; i < 3000; i++) run_cycle(i % 3 == 0);
    do_reset();
    repeat (600) run_cycle(1'b1);
    repeat (400) run_cycle(1'($urandom_range(0, 1)));
    do_reset();
    repeat (200) run_cycle(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
